// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write arbiter: FSM states and
// default frame-buffer geometry.
package fb_pkg;

  localparam int unsigned FB_DEPTH  = 230400;
  localparam int unsigned FB_ADDR_W = 18;
  localparam int unsigned PIX_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAM,
    DRAIN,
    OVL
  } fb_state_e;

endpackage

// File: rtl/fb_wr_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: camera FIFO read side,
// overlay request/grant side and the BRAM write port.
interface fb_wr_arbiter_if
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIX_W,
  parameter int unsigned ADDR_WIDTH = FB_ADDR_W
);

  logic                  i_cam_almostempty;
  logic                  o_cam_rd;
  logic [DATA_WIDTH-1:0] i_cam_rdata;
  logic                  i_ovl_req;
  logic [ADDR_WIDTH-1:0] i_ovl_addr;
  logic [DATA_WIDTH-1:0] i_ovl_data;
  logic                  o_ovl_gnt;
  logic                  o_mem_wr;
  logic [ADDR_WIDTH-1:0] o_mem_waddr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  o_frame_done;

  modport master (
    input  i_cam_almostempty, i_cam_rdata, i_ovl_req, i_ovl_addr, i_ovl_data,
    output o_cam_rd, o_ovl_gnt, o_mem_wr, o_mem_waddr, o_mem_wdata, o_frame_done
  );

  modport slave (
    output i_cam_almostempty, i_cam_rdata, i_ovl_req, i_ovl_addr, i_ovl_data,
    input  o_cam_rd, o_ovl_gnt, o_mem_wr, o_mem_waddr, o_mem_wdata, o_frame_done
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Raster-order camera write pointer: wraps at the end of the frame buffer and
// flags the final address of the frame.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned BRAM_DEPTH = FB_DEPTH,
  parameter int unsigned ADDR_WIDTH = FB_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  assign ptr_o  = ptr_q;
  assign last_o = (ptr_q == LAST_ADDR);

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = last_o ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Frame-buffer write-port arbiter: streams camera FIFO bursts into raster order
// and slots single overlay writes between bursts with bounded waiting.
module fb_wr_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = PIX_W,
  parameter int unsigned BRAM_DEPTH   = FB_DEPTH,
  parameter int unsigned ADDR_WIDTH   = FB_ADDR_W,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned OVL_MAX_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_flush,
  fb_wr_arbiter_if.master   bus
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam int unsigned WW = $clog2(OVL_MAX_WAIT + 2);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(OVL_MAX_WAIT);

  fb_state_e       state_q, state_d;
  logic            cam_rd_q, cam_rd_d;
  logic            rd_pend_q, rd_pend_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic [ADDR_WIDTH-1:0] cam_ptr;
  logic                  cam_last;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt, wr;

  fb_addr_gen #(
    .BRAM_DEPTH (BRAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .clr_i  (i_flush),
    .inc_i  (rd_pend_q),
    .ptr_o  (cam_ptr),
    .last_o (cam_last)
  );

  // Every CAM cycle carries a read, so the read that ends a burst is always
  // written back during DRAIN and IDLE never sees a word in flight.
  always_comb begin
    state_d   = state_q;
    cam_rd_d  = 1'b0;
    burst_d   = burst_q;
    wait_d    = wait_q;
    rd_pend_d = cam_rd_q & ~i_flush;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (bus.i_ovl_req && (wait_q == WAIT_MAX || bus.i_cam_almostempty)) begin
          state_d = OVL;
        end else if (!bus.i_cam_almostempty) begin
          state_d  = CAM;
          cam_rd_d = 1'b1;
        end
      end
      CAM: begin
        burst_d = burst_q + BW'(cam_rd_q);
        if (!bus.i_cam_almostempty && burst_q < BURST_LAST) begin
          cam_rd_d = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        if (bus.i_ovl_req) begin
          wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end else begin
          wait_d = '0;
        end
      end
      OVL: begin
        state_d = IDLE;
        wait_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d  = IDLE;
      cam_rd_d = 1'b0;
      burst_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cam_rd_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      burst_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cam_rd_q  <= cam_rd_d;
      rd_pend_q <= rd_pend_d;
      burst_q   <= burst_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    gnt   = 1'b0;
    wr    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state_q == OVL) begin
      gnt   = 1'b1;
      wr    = 1'b1;
      waddr = bus.i_ovl_addr;
      wdata = bus.i_ovl_data;
    end else if (rd_pend_q) begin
      wr    = 1'b1;
      waddr = cam_ptr;
      wdata = bus.i_cam_rdata;
    end
  end

  assign bus.o_cam_rd     = cam_rd_q;
  assign bus.o_ovl_gnt    = gnt;
  assign bus.o_mem_wr     = wr;
  assign bus.o_mem_waddr  = waddr;
  assign bus.o_mem_wdata  = wdata;
  assign bus.o_frame_done = rd_pend_q & cam_last;

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// Scoreboard bench for fb_wr_arbiter: camera words and overlay requests queue
// their expected BRAM writes; a negedge monitor retires them in order.
module tb_fb_wr_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 18;
  localparam int DEPTH = 1200;
  localparam int BL    = 8;
  localparam int MW    = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;
  logic flush = 1'b0;

  int nvec = 0;
  int nerr = 0;

  wr_t cam_q[$];
  wr_t ovl_q[$];
  wr_t e, got;
  int  model_ptr  = 0;
  int  fifo_cnt   = 0;
  int  cam_writes = 0;
  int  ovl_writes = 0;
  int  fd_cnt     = 0;
  int  n_full     = 0;
  int  n_short    = 0;
  int  rd_run     = 0;
  logic [AW-1:0] last_cam_addr = '0;

  fb_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fb_wr_arbiter #(
    .DATA_WIDTH   (DW),
    .BRAM_DEPTH   (DEPTH),
    .ADDR_WIDTH   (AW),
    .BURST_LEN    (BL),
    .OVL_MAX_WAIT (MW)
  ) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fifo_word(input int n);
    return DW'(n * 37 + 32'h1234);
  endfunction

  // FIFO model: a read strobe presents the next word in the following cycle.
  always @(posedge clk) begin
    if (bus.o_cam_rd) begin
      bus.i_cam_rdata <= fifo_word(fifo_cnt);
      fifo_cnt        <= fifo_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      cam_q.delete();
      model_ptr = 0;
      rd_run    = 0;
    end else begin
      got.addr = bus.o_mem_waddr;
      got.data = bus.o_mem_wdata;
      if (bus.o_mem_wr) begin
        if (bus.o_ovl_gnt) begin
          nvec++;
          if (ovl_q.size() == 0) begin
            nerr++;
            $display("FAIL ovl_write unexpected got %h/%h", got.addr, got.data);
          end else begin
            e = ovl_q.pop_front();
            if (got !== e) begin
              nerr++;
              $display("FAIL ovl_write got %h/%h exp %h/%h", got.addr, got.data, e.addr, e.data);
            end
          end
          nvec++;
          if (bus.o_frame_done !== 1'b0) begin
            nerr++;
            $display("FAIL ovl_frame_done got %b exp 0", bus.o_frame_done);
          end
          ovl_writes++;
        end else begin
          nvec++;
          if (cam_q.size() == 0) begin
            nerr++;
            $display("FAIL cam_write unexpected got %h/%h", got.addr, got.data);
          end else begin
            e = cam_q.pop_front();
            if (got !== e) begin
              nerr++;
              $display("FAIL cam_write got %h/%h exp %h/%h", got.addr, got.data, e.addr, e.data);
            end
            nvec++;
            if (bus.o_frame_done !== (e.addr == AW'(DEPTH - 1))) begin
              nerr++;
              $display("FAIL frame_done at %h got %b exp %b", e.addr, bus.o_frame_done,
                       (e.addr == AW'(DEPTH - 1)));
            end
          end
          cam_writes++;
          last_cam_addr = got.addr;
        end
      end else if (bus.o_ovl_gnt || bus.o_frame_done) begin
        nvec++;
        nerr++;
        $display("FAIL strobe_without_write gnt %b fd %b exp 0 0", bus.o_ovl_gnt, bus.o_frame_done);
      end
      if (bus.o_frame_done) fd_cnt++;
      if (bus.o_ovl_gnt) begin
        nvec++;
        if (bus.o_cam_rd !== 1'b0) begin
          nerr++;
          $display("FAIL gnt_rd_exclusive cam_rd %b exp 0", bus.o_cam_rd);
        end
      end
      if (bus.o_cam_rd) begin
        rd_run++;
        if (!flush) begin
          cam_q.push_back('{addr: AW'(model_ptr), data: fifo_word(fifo_cnt)});
          model_ptr = (model_ptr == DEPTH - 1) ? 0 : model_ptr + 1;
        end
      end else if (rd_run != 0) begin
        if (rd_run == BL) n_full++;
        else n_short++;
        rd_run = 0;
      end
      if (flush) model_ptr = 0;
    end
  end

  task automatic settle_idle();
    bus.i_cam_almostempty = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_cam_almostempty = 1'b1;
    bus.i_ovl_req  = 1'b1;
    bus.i_ovl_addr = AW'(5);
    bus.i_ovl_data = DW'(16'hAAAA);
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    nvec++;
    if ({bus.o_cam_rd, bus.o_ovl_gnt, bus.o_mem_wr, bus.o_frame_done} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_strobes got %b exp 0000",
               {bus.o_cam_rd, bus.o_ovl_gnt, bus.o_mem_wr, bus.o_frame_done});
    end
    nvec++;
    if ({bus.o_mem_waddr, bus.o_mem_wdata} !== '0) begin
      nerr++;
      $display("FAIL reset_bus got %h/%h exp 0/0", bus.o_mem_waddr, bus.o_mem_wdata);
    end
    bus.i_ovl_req = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if ({bus.o_cam_rd, bus.o_mem_wr} !== 2'b00) begin
        nerr++;
        $display("FAIL post_reset_idle got %b exp 00", {bus.o_cam_rd, bus.o_mem_wr});
      end
    end
    settle_idle();
  endtask

  task automatic test_frame();
    int start, fd0, cyc, w;
    start = cam_writes;
    fd0   = fd_cnt;
    n_full  = 0;
    n_short = 0;
    bus.i_cam_almostempty = 1'b0;
    for (cyc = 0; cyc < 4 * DEPTH; cyc++) begin
      @(posedge clk);
      if (cam_writes - start >= DEPTH + 3) break;
    end
    nvec++;
    if (cyc >= 4 * DEPTH) begin
      nerr++;
      $display("FAIL frame_timeout writes %0d exp %0d", cam_writes - start, DEPTH + 3);
    end
    nvec++;
    if (n_short != 0 || n_full < DEPTH / BL) begin
      nerr++;
      $display("FAIL burst_len full %0d short %0d exp >=%0d 0", n_full, n_short, DEPTH / BL);
    end
    #1;
    settle_idle();
    w = cam_writes - start;
    nvec++;
    if (fd_cnt - fd0 != 1) begin
      nerr++;
      $display("FAIL frame_done_count got %0d exp 1", fd_cnt - fd0);
    end
    nvec++;
    if (last_cam_addr !== AW'((w - 1) % DEPTH)) begin
      nerr++;
      $display("FAIL frame_wrap_addr got %0d exp %0d", last_cam_addr, (w - 1) % DEPTH);
    end
  endtask

  task automatic test_short_burst();
    int start, reads;
    settle_idle();
    start = cam_writes;
    reads = 0;
    bus.i_cam_almostempty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) bus.i_cam_almostempty = 1'b1;
      @(negedge clk);
      if (bus.o_cam_rd) reads++;
    end
    nvec++;
    if (reads != 3) begin
      nerr++;
      $display("FAIL short_reads got %0d exp 3", reads);
    end
    nvec++;
    if (cam_writes - start != 3) begin
      nerr++;
      $display("FAIL short_writes got %0d exp 3", cam_writes - start);
    end
  endtask

  task automatic test_ovl_idle();
    int start;
    settle_idle();
    start = ovl_writes;
    bus.i_ovl_req  = 1'b1;
    bus.i_ovl_addr = AW'(18'h002A5);
    bus.i_ovl_data = DW'(16'h07E0);
    ovl_q.push_back('{addr: AW'(18'h002A5), data: DW'(16'h07E0)});
    @(negedge clk);
    nvec++;
    if (bus.o_ovl_gnt !== 1'b0) begin
      nerr++;
      $display("FAIL ovl_idle_early got %b exp 0", bus.o_ovl_gnt);
    end
    @(negedge clk);
    nvec++;
    if ({bus.o_ovl_gnt, bus.o_mem_wr} !== 2'b11) begin
      nerr++;
      $display("FAIL ovl_idle_gnt got %b exp 11", {bus.o_ovl_gnt, bus.o_mem_wr});
    end
    bus.i_ovl_req = 1'b0;
    repeat (3) @(posedge clk);
    nvec++;
    if (ovl_writes - start != 1) begin
      nerr++;
      $display("FAIL ovl_idle_count got %0d exp 1", ovl_writes - start);
    end
  endtask

  task automatic test_ovl_busy();
    int cyc, falls;
    logic prev_rd;
    settle_idle();
    bus.i_cam_almostempty = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    prev_rd        = bus.o_cam_rd;
    falls          = 0;
    bus.i_ovl_req  = 1'b1;
    bus.i_ovl_addr = AW'(18'h00100);
    bus.i_ovl_data = DW'(16'hF800);
    ovl_q.push_back('{addr: AW'(18'h00100), data: DW'(16'hF800)});
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (prev_rd && !bus.o_cam_rd) falls++;
      prev_rd = bus.o_cam_rd;
      if (bus.o_ovl_gnt) break;
    end
    bus.i_ovl_req = 1'b0;
    nvec++;
    if (cyc > MW * (BL + 2) + 2) begin
      nerr++;
      $display("FAIL ovl_busy_latency got %0d exp <=%0d", cyc, MW * (BL + 2) + 2);
    end
    nvec++;
    if (falls > MW) begin
      nerr++;
      $display("FAIL ovl_busy_bursts got %0d exp <=%0d", falls, MW);
    end
    repeat (20) @(posedge clk);
    #1;
    settle_idle();
  endtask

  task automatic test_flush();
    int cyc, reads, wr;
    settle_idle();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    reads = 0;
    bus.i_cam_almostempty = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (bus.o_cam_rd) reads++;
      if (reads == 1000) begin
        bus.i_cam_almostempty = 1'b1;
        break;
      end
    end
    settle_idle();
    nvec++;
    if (last_cam_addr !== AW'(999)) begin
      nerr++;
      $display("FAIL flush_setup_addr got %0d exp 999", last_cam_addr);
    end
    wr = 0;
    bus.i_cam_almostempty = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) flush = 1'b1;
      if (i == 5) flush = 1'b0;
      @(negedge clk);
      if (bus.o_mem_wr && !bus.o_ovl_gnt) wr++;
      if (i == 5) begin
        nvec++;
        if ({bus.o_cam_rd, bus.o_mem_wr} !== 2'b00) begin
          nerr++;
          $display("FAIL flush_discard got %b exp 00", {bus.o_cam_rd, bus.o_mem_wr});
        end
      end
      if (i == 7) begin
        nvec++;
        if (bus.o_mem_wr !== 1'b1 || bus.o_mem_waddr !== '0) begin
          nerr++;
          $display("FAIL flush_restart got wr %b addr %0d exp 1 0", bus.o_mem_wr, bus.o_mem_waddr);
        end
      end
    end
    nvec++;
    if (wr != 5) begin
      nerr++;
      $display("FAIL flush_write_count got %0d exp 5", wr);
    end
    settle_idle();
  endtask

  task automatic test_reset_mid();
    int cyc;
    settle_idle();
    bus.i_cam_almostempty = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    nvec++;
    if (bus.o_cam_rd !== 1'b1) begin
      nerr++;
      $display("FAIL mid_burst_rd got %b exp 1", bus.o_cam_rd);
    end
    rstn = 1'b0;
    #1;
    nvec++;
    if ({bus.o_cam_rd, bus.o_ovl_gnt, bus.o_mem_wr, bus.o_frame_done} !== 4'b0) begin
      nerr++;
      $display("FAIL async_reset got %b exp 0000",
               {bus.o_cam_rd, bus.o_ovl_gnt, bus.o_mem_wr, bus.o_frame_done});
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (bus.o_mem_wr) break;
    end
    nvec++;
    if (cyc >= 20 || bus.o_mem_waddr !== '0) begin
      nerr++;
      $display("FAIL reset_restart got cyc %0d addr %0d exp <20 0", cyc, bus.o_mem_waddr);
    end
    repeat (12) @(posedge clk);
    #1;
    settle_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cam_almostempty = 1'b1;
    bus.i_ovl_req  = 1'b0;
    bus.i_ovl_addr = '0;
    bus.i_ovl_data = '0;
    test_reset();
    test_frame();
    test_short_burst();
    test_ovl_idle();
    test_ovl_busy();
    test_flush();
    test_reset_mid();
    nvec++;
    if (cam_q.size() != 0 || ovl_q.size() != 0) begin
      nerr++;
      $display("FAIL leftover_expected cam %0d ovl %0d exp 0 0", cam_q.size(), ovl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fb_wr_arbiter.md
Name: fb_wr_arbiter

Overview:
- Owns the single write port of the frame-buffer BRAM. Shares it between two requesters:
  - the camera input FIFO, which delivers bursts of pixels;
  - the colour-detect overlay writer, which issues single-word writes to arbitrary addresses (bounding-box markings).
- Sequences camera bursts into raster-order addresses, inserts overlay writes between bursts, and reports frame completion.
- Sits between the input FIFO, the overlay writer and the BRAM write port. The display read port is untouched.

Parameters:
- DATA_WIDTH, 16, pixel word width.
- BRAM_DEPTH, 230400, frame-buffer words; camera address wraps after BRAM_DEPTH-1.
- ADDR_WIDTH, 18, BRAM address width; must satisfy 2**ADDR_WIDTH >= BRAM_DEPTH.
- BURST_LEN, 8, maximum camera FIFO reads per grant.
- OVL_MAX_WAIT, 2, maximum consecutive camera bursts allowed while an overlay request is pending.

Ports:
- i_clk  in  1  system clock.
- i_rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- i_flush  in  1  synchronous; restart frame at address 0.
- i_cam_almostempty  in  1  input FIFO cannot supply another word.
- o_cam_rd  out  1  FIFO read strobe; data valid on i_cam_rdata one cycle later.
- i_cam_rdata  in  DATA_WIDTH  FIFO read data.
- i_ovl_req  in  1  overlay write request; held until granted.
- i_ovl_addr  in  ADDR_WIDTH  overlay target address, stable while i_ovl_req is high.
- i_ovl_data  in  DATA_WIDTH  overlay data, stable while i_ovl_req is high.
- o_ovl_gnt  out  1  one-cycle grant; the overlay write occurs in this same cycle.
- o_mem_wr  out  1  BRAM write enable.
- o_mem_waddr  out  ADDR_WIDTH  BRAM write address.
- o_mem_wdata  out  DATA_WIDTH  BRAM write data.
- o_frame_done  out  1  one-cycle pulse on the camera write to address BRAM_DEPTH-1.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - camera pointer 0, burst count 0, wait count 0, read-pending flag 0.
- States:
  - IDLE:
    - if i_ovl_req and (wait count == OVL_MAX_WAIT or i_cam_almostempty), go to OVL;
    - else if !i_cam_almostempty, go to CAM;
    - else stay in IDLE.
  - CAM:
    - o_cam_rd is registered; it is asserted in the next cycle only if the current i_cam_almostempty is 0 and burst count < BURST_LEN. Consequence: i_cam_almostempty high in cycle t means o_cam_rd is low in cycle t+1.
    - Burst count increments on each o_cam_rd.
    - Exit to DRAIN when BURST_LEN reads have been issued or i_cam_almostempty stops the burst.
  - DRAIN:
    - one cycle; completes the write of the last in-flight word.
    - Increments wait count if i_ovl_req is high, else clears it.
    - Returns to IDLE.
  - OVL:
    - one cycle; o_ovl_gnt=1, o_mem_wr=1, o_mem_waddr=i_ovl_addr, o_mem_wdata=i_ovl_data.
    - Clears wait count and returns to IDLE.
- Camera write path:
  - o_cam_rd in cycle t produces o_mem_wr=1 in cycle t+1, with o_mem_wdata=i_cam_rdata and o_mem_waddr=camera pointer.
  - The pointer then increments, wrapping from BRAM_DEPTH-1 to 0.
  - o_frame_done pulses in the same cycle as the write to BRAM_DEPTH-1.
  - Camera addresses are strictly sequential: no skips, never >= BRAM_DEPTH.
- Mutual exclusion:
  - OVL is entered only when no camera read is in flight, so camera and overlay writes never share a cycle.
  - o_ovl_gnt and o_cam_rd are never high together.
- Starvation bound: a pending overlay request is granted after at most OVL_MAX_WAIT camera bursts.
- Flush:
  - o_cam_rd is low in the next cycle.
  - Any in-flight camera word is discarded (no write).
  - Pointer goes to 0, burst count clears, state goes to IDLE.
  - An OVL cycle coinciding with flush still completes its write and grant.
- Overlay priority when FIFO is idle: with i_cam_almostempty high, a pending overlay request is granted from IDLE without waiting.
- Mid-operation reset: asynchronous. All outputs drop to 0 immediately; no partial write is issued after release.

Decomposition:
- Shared package fb_pkg holds:
  - state enum (IDLE, CAM, DRAIN, OVL);
  - default constants FB_DEPTH=230400, FB_ADDR_W=18, PIX_W=16.
- Optional sub-module fb_addr_gen: wrapping camera pointer with clear/increment inputs and a last-address flag that drives o_frame_done. The arbiter FSM stays in the top module.

Test Plan:
- FIFO always ready, no overlay -> reads in bursts of 8. After 230400 writes, addresses run 0..230399, o_frame_done pulses exactly once, then the pointer wraps to 0.
- i_cam_almostempty rises after 3 reads of a burst -> o_cam_rd low the next cycle, exactly 3 writes at consecutive addresses, state returns through DRAIN to IDLE.
- Overlay request (addr 0x00100, data 0xF800) during continuous camera traffic -> o_ovl_gnt within 2 bursts plus DRAIN. Write to 0x00100 with 0xF800; the camera pointer is not disturbed.
- Overlay request with FIFO empty -> grant and write 2 cycles after i_ovl_req rises (IDLE, then OVL).
- i_flush on the 5th read of a burst at pointer 1000 -> the in-flight word is not written, and the next camera write goes to address 0.
- i_rstn low mid-burst -> o_mem_wr, o_cam_rd and o_ovl_gnt are 0 immediately. After release, the first camera write goes to address 0.
